// File: rtl/mult_arb_pkg.sv
// rtl/mult_arb_pkg.sv - shared FSM state type and width helpers for mult_arbiter
package mult_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    RESP = 2'd2
  } state_t;

  // Requester ID width; never narrower than one bit.
  function automatic int id_wid(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mult_arbiter_rr_picker.sv
// rtl/mult_arbiter_rr_picker.sv - combinational round-robin pick starting at ptr, wrapping modulo N_REQ
module rr_picker #(
  parameter int N_REQ  = 4,
  parameter int ID_WID = 2
) (
  input  logic [N_REQ-1:0]  req_valid,
  input  logic [ID_WID-1:0] ptr,
  output logic [N_REQ-1:0]  grant,
  output logic [ID_WID-1:0] idx,
  output logic              any
);

  logic [ID_WID-1:0] w_k;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    w_k   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      w_k = ID_WID'((int'(ptr) + i) % N_REQ);
      if (!any && req_valid[w_k]) begin
        any        = 1'b1;
        grant[w_k] = 1'b1;
        idx        = w_k;
      end
    end
  end

endmodule

// File: rtl/multiplier_cla.sv
// rtl/multiplier_cla.sv - combinational unsigned array multiplier built from carry-lookahead adder stages
module multiplier_cla #(
  parameter int MULTICAND_WID  = 16,
  parameter int MULTIPLIER_WID = 16
) (
  input  logic [MULTICAND_WID-1:0]                multicand,
  input  logic [MULTIPLIER_WID-1:0]               multiplier,
  output logic [MULTICAND_WID+MULTIPLIER_WID-1:0] product
);

  localparam int PW = MULTICAND_WID + MULTIPLIER_WID;

  // Generate/propagate adder: carries follow c[i+1] = g[i] | p[i]&c[i].
  function automatic logic [PW-1:0] cla_add(input logic [PW-1:0] x, input logic [PW-1:0] y);
    logic [PW-1:0] g;
    logic [PW-1:0] p;
    logic [PW:0]   c;
    g = x & y;
    p = x ^ y;
    c = '0;
    for (int i = 0; i < PW; i++) begin
      c[i+1] = g[i] | (p[i] & c[i]);
    end
    return p ^ c[PW-1:0];
  endfunction

  logic [PW-1:0] w_acc [MULTIPLIER_WID+1];

  assign w_acc[0] = '0;

  for (genvar j = 0; j < MULTIPLIER_WID; j++) begin : g_stage
    logic [PW-1:0] w_pp;
    assign w_pp       = multiplier[j] ? ({{MULTIPLIER_WID{1'b0}}, multicand} << j) : '0;
    assign w_acc[j+1] = cla_add(w_acc[j], w_pp);
  end

  assign product = w_acc[MULTIPLIER_WID];

endmodule

// File: rtl/mult_arbiter.sv
// rtl/mult_arbiter.sv - round-robin sequencer sharing one multiplier_cla among N_REQ requesters
// Optional MULT_ARB_SIGNED_EN: two's-complement operands via sign-magnitude around the unsigned multiplier.
module mult_arbiter
  import mult_arb_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int A_WID      = 16,
  parameter int B_WID      = 16,
  parameter int MUL_CYCLES = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_REQ-1:0]         req_valid,
  output logic [N_REQ-1:0]         req_ready,
  input  logic [N_REQ*A_WID-1:0]   req_a,
  input  logic [N_REQ*B_WID-1:0]   req_b,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [$clog2(N_REQ)-1:0] resp_id,
  output logic [A_WID+B_WID-1:0]   resp_product,
  output logic                     busy
);

  localparam int IW = id_wid(N_REQ);
  localparam int PW = A_WID + B_WID;
  localparam int CW = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;

  state_t          r_state;
  logic [IW-1:0]   r_ptr;
  logic [CW-1:0]   r_cnt;
  logic [A_WID-1:0] r_a;
  logic [B_WID-1:0] r_b;
  logic [IW-1:0]   r_id;
  logic [PW-1:0]   r_product;

  logic [N_REQ-1:0] w_grant;
  logic [IW-1:0]    w_idx;
  logic             w_any;
  logic             w_take;
  logic [IW-1:0]    w_next_ptr;
  logic [A_WID-1:0] w_sel_a;
  logic [B_WID-1:0] w_sel_b;
  logic [A_WID-1:0] w_cap_a;
  logic [B_WID-1:0] w_cap_b;
  logic [PW-1:0]    w_mul_p;
  logic [PW-1:0]    w_res;

  rr_picker #(
    .N_REQ  (N_REQ),
    .ID_WID (IW)
  ) u_picker (
    .req_valid (req_valid),
    .ptr       (r_ptr),
    .grant     (w_grant),
    .idx       (w_idx),
    .any       (w_any)
  );

  // Operands come only from the capture registers so the multiplier is a clean multicycle path.
  multiplier_cla #(
    .MULTICAND_WID  (A_WID),
    .MULTIPLIER_WID (B_WID)
  ) u_mul (
    .multicand  (r_a),
    .multiplier (r_b),
    .product    (w_mul_p)
  );

  always_comb begin
    w_sel_a = '0;
    w_sel_b = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (w_grant[k]) begin
        w_sel_a = req_a[k*A_WID +: A_WID];
        w_sel_b = req_b[k*B_WID +: B_WID];
      end
    end
  end

  assign w_take     = (r_state == IDLE) && w_any;
  assign w_next_ptr = (w_idx == IW'(N_REQ - 1)) ? '0 : w_idx + IW'(1);

`ifdef MULT_ARB_SIGNED_EN
  logic r_sign;
  logic w_cap_sign;

  // The most negative value maps to 2^(W-1), which still fits the unsigned W-bit magnitude.
  assign w_cap_a    = w_sel_a[A_WID-1] ? -w_sel_a : w_sel_a;
  assign w_cap_b    = w_sel_b[B_WID-1] ? -w_sel_b : w_sel_b;
  assign w_cap_sign = w_sel_a[A_WID-1] ^ w_sel_b[B_WID-1];
  assign w_res      = r_sign ? -w_mul_p : w_mul_p;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sign <= 1'b0;
    end else if (w_take) begin
      r_sign <= w_cap_sign;
    end
  end
`else
  assign w_cap_a = w_sel_a;
  assign w_cap_b = w_sel_b;
  assign w_res   = w_mul_p;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_ptr     <= '0;
      r_cnt     <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_id      <= '0;
      r_product <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_a     <= w_cap_a;
            r_b     <= w_cap_b;
            r_id    <= w_idx;
            r_ptr   <= w_next_ptr;
            r_cnt   <= CW'(MUL_CYCLES - 1);
            r_state <= MUL;
          end
        end
        MUL: begin
          if (r_cnt == '0) begin
            r_product <= w_res;
            r_state   <= RESP;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        RESP: begin
          if (resp_ready) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Gated by rst_n so no requester sees an accept while reset is held.
  assign req_ready    = (rst_n && (r_state == IDLE)) ? w_grant : '0;
  assign resp_valid   = (r_state == RESP);
  assign resp_id      = r_id;
  assign resp_product = r_product;
  assign busy         = (r_state != IDLE);

endmodule
